// File: rtl/plic_pkg.sv
// Shared sizes and types for the PLIC gateway/arbitration core.
package plic_pkg;

    localparam int unsigned IRQ_NUM    = 32;
    localparam int unsigned PRIO_WIDTH = 4;
    localparam int unsigned GWP_WIDTH  = 3;
    localparam int unsigned IRQ_WIDTH  = $clog2(IRQ_NUM);

    localparam logic TM_LEVL = 1'b0;
    localparam logic TM_EDGE = 1'b1;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    typedef logic [IRQ_WIDTH-1:0] irq_id_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: level/edge request qualification, edge queue and the
// IDLE/PEND/CLAIMED handshake state that produces the pending bit.
module plic_gateway
    import plic_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tm_i,
    input  logic [GWP_WIDTH-1:0] tnm_i,
    input  logic                 irq_i,
    input  logic                 claim_hit_i,
    input  logic                 complete_hit_i,
    output logic                 ip_o
);

    gw_state_e            state_q, state_d;
    logic [GWP_WIDTH-1:0] cnt_q, cnt_d;
    logic [GWP_WIDTH-1:0] cnt_max;
    logic                 irq_q;
    logic                 ip_q, ip_d;
    logic                 rise;
    logic                 req;
    logic                 fwd;

    always_comb begin
        cnt_max = (tnm_i == '0) ? GWP_WIDTH'(1) : tnm_i;
        rise    = irq_i & ~irq_q;
        req     = (tm_i == TM_EDGE) ? (cnt_q != '0) : irq_i;
        fwd     = (state_q == GW_IDLE) && req;

        state_d = state_q;
        case (state_q)
            GW_IDLE:    if (req)            state_d = GW_PEND;
            GW_PEND:    if (claim_hit_i)    state_d = GW_CLAIMED;
            GW_CLAIMED: if (complete_hit_i) state_d = GW_IDLE;
            default:                        state_d = GW_IDLE;
        endcase

        // A forward and a new edge in the same cycle cancel out.
        cnt_d = cnt_q;
        if (tm_i == TM_LEVL) begin
            cnt_d = '0;
        end else if (rise && !fwd) begin
            cnt_d = (cnt_q >= cnt_max) ? cnt_q : cnt_q + GWP_WIDTH'(1);
        end else if (!rise && fwd) begin
            cnt_d = cnt_q - GWP_WIDTH'(1);
        end

        ip_d = (state_d == GW_PEND);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= GW_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            ip_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_i;
            ip_q    <= ip_d;
        end
    end

    assign ip_o = ip_q;

endmodule

// File: rtl/plic_claim_arbiter.sv
// PLIC core: gateways per source, priority/threshold arbitration, the
// claim/complete decode and the registered external interrupt to the hart.
module plic_claim_arbiter
    import plic_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic [GWP_WIDTH-1:0]          tnm_i,
    input  logic [IRQ_NUM-1:0]            tm_i,
    input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_NUM-1:0]            ie_i,
    input  logic [IRQ_WIDTH-1:0]          thold_i,
    input  logic [IRQ_NUM-1:0]            irq_i,
    input  logic                          claim_i,
    input  logic                          complete_i,
    input  logic [IRQ_WIDTH-1:0]          complete_id_i,
    output logic [IRQ_WIDTH-1:0]          claim_id_o,
    output logic [IRQ_NUM-1:0]            ip_o,
    output logic                          ext_irq_o
);

    logic [IRQ_NUM-1:0]    ip_w;
    irq_id_t               best_id_q, best_id_d;
    logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
    irq_id_t               claim_id_q, claim_id_d;
    logic                  ext_irq_q, ext_irq_d;
    logic                  claim_ok;

    assign ip_w[0] = 1'b0;

    for (genvar g = 1; g < IRQ_NUM; g++) begin : g_gw
        plic_gateway u_gw (
            .clk_i          (clk_i),
            .rst_n_i        (rst_n_i),
            .tm_i           (tm_i[g]),
            .tnm_i          (tnm_i),
            .irq_i          (irq_i[g]),
            .claim_hit_i    (claim_ok && (best_id_q == irq_id_t'(g))),
            .complete_hit_i (complete_i && (complete_id_i == irq_id_t'(g))),
            .ip_o           (ip_w[g])
        );
    end

    // Linear priority scan; strict '>' keeps the lowest ID on ties.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int unsigned k = 1; k < IRQ_NUM; k++) begin
            if (ip_w[k] && ie_i[k] &&
                (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio_d)) begin
                best_prio_d = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
                best_id_d   = irq_id_t'(k);
            end
        end
        ext_irq_d = en_i && (IRQ_WIDTH'(best_prio_d) > thold_i);
    end

    // A claim only returns a source that is still pending; stale winners give 0.
    always_comb begin
        claim_ok   = claim_i && en_i && ext_irq_q &&
                     (best_id_q != '0) && ip_w[best_id_q];
        claim_id_d = claim_id_q;
        if (claim_i) begin
            claim_id_d = claim_ok ? best_id_q : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_id_q  <= '0;
            ext_irq_q   <= 1'b0;
        end else begin
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_id_q  <= claim_id_d;
            ext_irq_q   <= ext_irq_d;
        end
    end

    assign claim_id_o = claim_id_q;
    assign ip_o       = ip_w;
    assign ext_irq_o  = ext_irq_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed table-driven bench for plic_claim_arbiter.
module tb_plic_claim_arbiter;
    import plic_pkg::*;

    typedef struct {
        logic                 rst_n;
        logic                 en;
        logic [IRQ_WIDTH-1:0] thold;
        logic [3:0]           p9;
        logic [31:0]          irq;
        logic                 claim;
        logic                 cmp;
        logic [IRQ_WIDTH-1:0] cid;
        logic [31:0]          exp_ip;
        logic [IRQ_WIDTH-1:0] exp_cid;
        logic                 exp_ext;
    } vec_t;

    logic                          clk;
    logic                          rst_n;
    logic                          en;
    logic [GWP_WIDTH-1:0]          tnm;
    logic [IRQ_NUM-1:0]            tm;
    logic [IRQ_NUM*PRIO_WIDTH-1:0] prio;
    logic [IRQ_NUM-1:0]            ie;
    logic [IRQ_WIDTH-1:0]          thold;
    logic [IRQ_NUM-1:0]            irq;
    logic                          claim;
    logic                          complete;
    logic [IRQ_WIDTH-1:0]          complete_id;
    logic [IRQ_WIDTH-1:0]          claim_id;
    logic [IRQ_NUM-1:0]            ip;
    logic                          ext_irq;
    logic [3:0]                    p9;

    int   nvec;
    int   nerr;
    vec_t vq[$];
    logic                 c_rst;
    logic                 c_en;
    logic [IRQ_WIDTH-1:0] c_th;
    logic [3:0]           c_p9;

    plic_claim_arbiter dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .tnm_i         (tnm),
        .tm_i          (tm),
        .prio_i        (prio),
        .ie_i          (ie),
        .thold_i       (thold),
        .irq_i         (irq),
        .claim_i       (claim),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .claim_id_o    (claim_id),
        .ip_o          (ip),
        .ext_irq_o     (ext_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        prio        = '0;
        prio[2*4+:4] = 4'd7;
        prio[3*4+:4] = 4'd5;
        prio[4*4+:4] = 4'd7;
        prio[5*4+:4] = 4'd6;
        prio[6*4+:4] = 4'd3;
        prio[9*4+:4] = p9;
    end

    function automatic logic [31:0] b(input int n);
        return 32'd1 << n;
    endfunction

    task automatic v(input logic [31:0] i_irq, input logic i_cl, input logic i_co,
                     input int i_cid, input logic [31:0] e_ip, input int e_cid,
                     input logic e_ext);
        vec_t r;
        r.rst_n = c_rst; r.en = c_en; r.thold = c_th; r.p9 = c_p9;
        r.irq = i_irq; r.claim = i_cl; r.cmp = i_co; r.cid = IRQ_WIDTH'(i_cid);
        r.exp_ip = e_ip; r.exp_cid = IRQ_WIDTH'(e_cid); r.exp_ext = e_ext;
        vq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] e_ip,
                         input logic [IRQ_WIDTH-1:0] e_cid, input logic e_ext);
        nvec++;
        if (ip !== e_ip) begin
            nerr++;
            $display("FAIL %s ip_o: got %h expected %h", name, ip, e_ip);
        end
        nvec++;
        if (claim_id !== e_cid) begin
            nerr++;
            $display("FAIL %s claim_id_o: got %0d expected %0d", name, claim_id, e_cid);
        end
        nvec++;
        if (ext_irq !== e_ext) begin
            nerr++;
            $display("FAIL %s ext_irq_o: got %b expected %b", name, ext_irq, e_ext);
        end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0; en = 1'b1; tnm = 3'd2; tm = b(6); ie = 32'hFFFF_FFFE;
        thold = 5'd2; irq = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;
        p9 = 4'd7;
        c_rst = 1'b1; c_en = 1'b1; c_th = 5'd2; c_p9 = 4'd7;

        // Level source 3: latency, claim, no re-pend until complete
        v(b(3), 0, 0, 0, b(3), 0, 0);
        v(b(3), 0, 0, 0, b(3), 0, 1);
        v(b(3), 1, 0, 0, 0,    3, 1);
        v(b(3), 0, 0, 0, 0,    3, 0);
        v(b(3), 0, 0, 0, 0,    3, 0);
        v(b(3), 0, 1, 3, 0,    3, 0);
        v(b(3), 0, 0, 0, b(3), 3, 0);
        v(0,    0, 0, 0, b(3), 3, 1);
        v(0,    1, 0, 0, 0,    3, 1);
        v(0,    0, 1, 3, 0,    3, 0);
        v(0,    0, 0, 0, 0,    3, 0);
        // Equal priority 4/9: lowest ID first; back-to-back claim returns 0
        v(b(4)|b(9), 0, 0, 0, b(4)|b(9), 3, 0);
        v(0,         0, 0, 0, b(4)|b(9), 3, 1);
        v(0,         1, 0, 0, b(9),      4, 1);
        v(0,         1, 0, 0, b(9),      0, 1);
        v(0,         0, 0, 0, b(9),      0, 1);
        v(0,         1, 0, 0, 0,         9, 1);
        v(0,         0, 1, 4, 0,         9, 0);
        v(0,         0, 1, 9, 0,         9, 0);
        // Source 9 raised to priority 8 wins
        c_p9 = 4'd8;
        v(b(4)|b(9), 0, 0, 0, b(4)|b(9), 9, 0);
        v(0,         0, 0, 0, b(4)|b(9), 9, 1);
        v(0,         1, 0, 0, b(4),      9, 1);
        v(0,         0, 0, 0, b(4),      9, 1);
        v(0,         1, 0, 0, 0,         4, 1);
        v(0,         0, 1, 9, 0,         4, 0);
        v(0,         0, 1, 4, 0,         4, 0);
        c_p9 = 4'd7;
        // Threshold equal to priority blocks, one lower passes
        c_th = 5'd7;
        v(b(2), 0, 0, 0, b(2), 4, 0);
        v(0,    0, 0, 0, b(2), 4, 0);
        v(0,    1, 0, 0, b(2), 0, 0);
        c_th = 5'd6;
        v(0,    0, 0, 0, b(2), 0, 1);
        v(0,    1, 0, 0, 0,    2, 1);
        c_th = 5'd2;
        v(0,    0, 1, 2, 0,    2, 0);
        // Global enable off: gateways run, no interrupt, claim returns 0
        c_en = 1'b0;
        v(b(3), 0, 0, 0, b(3), 2, 0);
        v(0,    0, 0, 0, b(3), 2, 0);
        v(0,    1, 0, 0, b(3), 0, 0);
        c_en = 1'b1;
        v(0,    0, 0, 0, b(3), 0, 1);
        v(0,    1, 0, 0, 0,    3, 1);
        v(0,    0, 1, 3, 0,    3, 0);
        // Completes for PEND source, ID 0 and ID 31 are ignored
        v(b(5), 0, 0, 0,  b(5), 3, 0);
        v(0,    0, 1, 5,  b(5), 3, 1);
        v(0,    0, 1, 0,  b(5), 3, 1);
        v(0,    0, 1, 31, b(5), 3, 1);
        v(0,    1, 0, 0,  0,    5, 1);
        v(0,    0, 1, 5,  0,    5, 0);
        // Simultaneous claim and complete
        v(b(3)|b(4), 0, 0, 0, b(3)|b(4), 5, 0);
        v(0,         0, 0, 0, b(3)|b(4), 5, 1);
        v(0,         1, 0, 0, b(3),      4, 1);
        v(0,         0, 0, 0, b(3),      4, 1);
        v(0,         1, 1, 4, 0,         3, 1);
        v(0,         1, 1, 3, 0,         0, 0);
        v(0,         0, 0, 0, 0,         0, 0);
        v(b(3)|b(4), 0, 0, 0, b(3)|b(4), 0, 0);
        v(0,         0, 0, 0, b(3)|b(4), 0, 1);
        v(0,         1, 0, 0, b(3),      4, 1);
        v(0,         0, 0, 0, b(3),      4, 1);
        v(0,         1, 0, 0, 0,         3, 1);
        v(0,         0, 1, 4, 0,         3, 0);
        v(0,         0, 1, 3, 0,         3, 0);
        // Edge source 6: queue saturates at tnm=2 -> claims 6, 6, 0
        v(b(6), 0, 0, 0, 0,    3, 0);
        v(0,    0, 0, 0, b(6), 3, 0);
        v(0,    0, 0, 0, b(6), 3, 1);
        v(0,    1, 0, 0, 0,    6, 1);
        for (int p = 0; p < 5; p++) begin
            v(b(6), 0, 0, 0, 0, 6, 0);
            if (p < 4) v(0, 0, 0, 0, 0, 6, 0);
        end
        v(0, 0, 1, 6, 0,    6, 0);
        v(0, 0, 0, 0, b(6), 6, 0);
        v(0, 0, 0, 0, b(6), 6, 1);
        v(0, 1, 0, 0, 0,    6, 1);
        v(0, 0, 1, 6, 0,    6, 0);
        v(0, 0, 0, 0, b(6), 6, 0);
        v(0, 0, 0, 0, b(6), 6, 1);
        v(0, 1, 0, 0, 0,    6, 1);
        v(0, 0, 1, 6, 0,    6, 0);
        v(0, 0, 0, 0, 0,    6, 0);
        v(0, 1, 0, 0, 0,    0, 0);
        // Reset with src 3 CLAIMED and src 6 CLAIMED holding cnt=2
        v(b(3)|b(6), 0, 0, 0, b(3),      0, 0);
        v(b(3),      0, 0, 0, b(3)|b(6), 0, 1);
        v(b(3),      1, 0, 0, b(6),      3, 1);
        v(b(3),      0, 0, 0, b(6),      3, 1);
        v(b(3),      1, 0, 0, 0,         6, 1);
        v(b(3)|b(6), 0, 0, 0, 0,         6, 0);
        v(b(3),      0, 0, 0, 0,         6, 0);
        v(b(3)|b(6), 0, 0, 0, 0,         6, 0);
        c_rst = 1'b0;
        v(0, 0, 0, 0, 0, 0, 0);
        c_rst = 1'b1;
        v(b(6), 0, 0, 0, 0,    0, 0);
        v(0,    0, 0, 0, b(6), 0, 0);
        v(0,    0, 0, 0, b(6), 0, 1);
        v(0,    1, 0, 0, 0,    6, 1);
        v(0,    0, 1, 6, 0,    6, 0);
        v(0,    0, 0, 0, 0,    6, 0);
        v(b(3), 0, 0, 0, b(3), 6, 0);
        v(0,    0, 0, 0, b(3), 6, 1);
        v(0,    1, 0, 0, 0,    3, 1);
        v(0,    0, 1, 3, 0,    3, 0);

        // Reset state
        tick();
        tick();
        check("reset", 32'd0, 5'd0, 1'b0);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            rst_n = vq[k].rst_n; en = vq[k].en; thold = vq[k].thold; p9 = vq[k].p9;
            irq = vq[k].irq; claim = vq[k].claim; complete = vq[k].cmp;
            complete_id = vq[k].cid;
            tick();
            check($sformatf("vec%0d", k), vq[k].exp_ip, vq[k].exp_cid, vq[k].exp_ext);
        end
        rst_n = 1'b1; claim = 1'b0; complete = 1'b0; irq = '0;

        // Mid-run reset while the interrupt line is high
        irq = b(2);
        tick();
        irq = '0;
        tick();
        claim = 1'b1;
        tick();
        claim = 1'b0;
        check("pre_rst", 32'd0, 5'd2, 1'b1);
        irq = b(5);
        tick();
        irq = '0;
        tick();
        check("pre_rst2", b(5), 5'd2, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst", 32'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst", 32'd0, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
